decode_stage: RTL and testbench

- Registered RV32I decode stage between fetch and execute; successor to the combinational decoder.
- Accepts one instruction plus PC per handshake and produces a registered control/operand bundle one cycle later.
- Adds XLEN parametrisation, valid/ready flow control, a load-use hazard stall, flush and an illegal-instruction flag.
- Register-file reads and ALU/JBL/LS execution stay downstream; this block carries register addresses and immediates only.

---
 rtl/decode_stage_if.sv | 43 ++++
 rtl/decode_stage.sv | 258 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle signals of the registered RV32I decode stage.
// master: surrounding pipeline (fetch side + execute side); slave: the decode stage.
interface decode_stage_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALU_SEL_W  = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           in_instr;
   logic [XLEN-1:0]       in_pc;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       out_pc;
   logic [ALU_SEL_W-1:0]  out_alu_sel;
   logic                  out_alu_src_imm;
   logic [XLEN-1:0]       out_imm;
   logic [REG_ADDR_W-1:0] out_rs1;
   logic [REG_ADDR_W-1:0] out_rs2;
   logic [REG_ADDR_W-1:0] out_rd;
   logic                  out_rf_we;
   logic                  out_is_load;
   logic                  out_is_store;
   logic                  out_is_branch;
   logic                  out_is_jal;
   logic                  out_is_jalr;
   logic [2:0]            out_funct3;
   logic                  out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_alu_sel, out_alu_src_imm, out_imm,
             out_rs1, out_rs2, out_rd, out_rf_we, out_is_load, out_is_store,
             out_is_branch, out_is_jal, out_is_jalr, out_funct3, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_alu_sel, out_alu_src_imm, out_imm,
             out_rs1, out_rs2, out_rd, out_rf_we, out_is_load, out_is_store,
             out_is_branch, out_is_jal, out_is_jalr, out_funct3, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one instruction per handshake, bundle valid one cycle later,
// with load-use stall, flush and illegal-instruction flag.
module decode_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALU_SEL_W  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   decode_stage_if.slave         bus,
   input  logic                  flush,
   input  logic                  ex_load_valid,
   input  logic [REG_ADDR_W-1:0] ex_load_rd
);
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [ALU_SEL_W-1:0] ALU_ADD   = ALU_SEL_W'(4'd0);
   localparam logic [ALU_SEL_W-1:0] ALU_SUB   = ALU_SEL_W'(4'd1);
   localparam logic [ALU_SEL_W-1:0] ALU_SLT   = ALU_SEL_W'(4'd2);
   localparam logic [ALU_SEL_W-1:0] ALU_SLTU  = ALU_SEL_W'(4'd3);
   localparam logic [ALU_SEL_W-1:0] ALU_AND   = ALU_SEL_W'(4'd4);
   localparam logic [ALU_SEL_W-1:0] ALU_OR    = ALU_SEL_W'(4'd5);
   localparam logic [ALU_SEL_W-1:0] ALU_XOR   = ALU_SEL_W'(4'd6);
   localparam logic [ALU_SEL_W-1:0] ALU_SLL   = ALU_SEL_W'(4'd7);
   localparam logic [ALU_SEL_W-1:0] ALU_SRL   = ALU_SEL_W'(4'd8);
   localparam logic [ALU_SEL_W-1:0] ALU_SRA   = ALU_SEL_W'(4'd9);
   localparam logic [ALU_SEL_W-1:0] ALU_LUI   = ALU_SEL_W'(4'd10);
   localparam logic [ALU_SEL_W-1:0] ALU_AUIPC = ALU_SEL_W'(4'd11);

   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic [ALU_SEL_W-1:0]  alu_sel;
      logic                  src_imm;
      logic [XLEN-1:0]       imm;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic                  rf_we;
      logic                  is_load;
      logic                  is_store;
      logic                  is_branch;
      logic                  is_jal;
      logic                  is_jalr;
      logic [2:0]            funct3;
      logic                  illegal;
   } bundle_t;

   function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // alt selects SUB/SRA over ADD/SRL (instr[30] on the register-register forms)
   function automatic logic [ALU_SEL_W-1:0] alu_of(input logic [2:0] f3, input logic alt);
      logic [ALU_SEL_W-1:0] sel;
      case (f3)
         3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
         3'b001:  sel = ALU_SLL;
         3'b010:  sel = ALU_SLT;
         3'b011:  sel = ALU_SLTU;
         3'b100:  sel = ALU_XOR;
         3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
         3'b110:  sel = ALU_OR;
         default: sel = ALU_AND;
      endcase
      return sel;
   endfunction

   logic [31:0]           instr_s;
   logic [6:0]            opcode_s;
   logic [2:0]            f3_s;
   logic [6:0]            f7_s;
   logic [REG_ADDR_W-1:0] rs1_f_s, rs2_f_s, rd_f_s;
   logic [31:0]           imm_i_s, imm_st_s, imm_br_s, imm_u_s, imm_j_s;
   bundle_t               dec_s;
   bundle_t               out_r;
   logic                  out_valid_r;
   logic                  hazard_s, in_ready_s, accept_s;

   assign instr_s  = bus.in_instr;
   assign opcode_s = instr_s[6:0];
   assign f3_s     = instr_s[14:12];
   assign f7_s     = instr_s[31:25];
   assign rs1_f_s  = REG_ADDR_W'(instr_s[19:15]);
   assign rs2_f_s  = REG_ADDR_W'(instr_s[24:20]);
   assign rd_f_s   = REG_ADDR_W'(instr_s[11:7]);
   assign imm_i_s  = {{20{instr_s[31]}}, instr_s[31:20]};
   assign imm_st_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
   assign imm_br_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
   assign imm_u_s  = {instr_s[31:12], 12'd0};
   assign imm_j_s  = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

   // Combinational decode of the presented instruction; unused register fields stay 0.
   always_comb begin
      dec_s    = {$bits(bundle_t){1'b0}};
      dec_s.pc = bus.in_pc;
      case (opcode_s)
         OPC_LUI, OPC_AUIPC: begin
            dec_s.alu_sel = (opcode_s == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
            dec_s.src_imm = 1'b1;
            dec_s.imm     = sext(imm_u_s);
            dec_s.rd      = rd_f_s;
            dec_s.rf_we   = 1'b1;
         end
         OPC_JAL: begin
            dec_s.imm    = sext(imm_j_s);
            dec_s.rd     = rd_f_s;
            dec_s.rf_we  = 1'b1;
            dec_s.is_jal = 1'b1;
         end
         OPC_JALR: begin
            if (f3_s == 3'b000) begin
               dec_s.src_imm = 1'b1;
               dec_s.imm     = sext(imm_i_s);
               dec_s.rs1     = rs1_f_s;
               dec_s.rd      = rd_f_s;
               dec_s.rf_we   = 1'b1;
               dec_s.is_jalr = 1'b1;
            end else begin
               dec_s.illegal = 1'b1;
            end
         end
         OPC_BRANCH: begin
            case (f3_s)
               3'b010, 3'b011: dec_s.illegal = 1'b1;
               default: begin
                  dec_s.imm       = sext(imm_br_s);
                  dec_s.rs1       = rs1_f_s;
                  dec_s.rs2       = rs2_f_s;
                  dec_s.is_branch = 1'b1;
                  dec_s.funct3    = f3_s;
               end
            endcase
         end
         OPC_LOAD: begin
            case (f3_s)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
                  dec_s.src_imm = 1'b1;
                  dec_s.imm     = sext(imm_i_s);
                  dec_s.rs1     = rs1_f_s;
                  dec_s.rd      = rd_f_s;
                  dec_s.rf_we   = 1'b1;
                  dec_s.is_load = 1'b1;
                  dec_s.funct3  = f3_s;
               end
               default: dec_s.illegal = 1'b1;
            endcase
         end
         OPC_STORE: begin
            case (f3_s)
               3'b000, 3'b001, 3'b010: begin
                  dec_s.src_imm  = 1'b1;
                  dec_s.imm      = sext(imm_st_s);
                  dec_s.rs1      = rs1_f_s;
                  dec_s.rs2      = rs2_f_s;
                  dec_s.is_store = 1'b1;
                  dec_s.funct3   = f3_s;
               end
               default: dec_s.illegal = 1'b1;
            endcase
         end
         OPC_OPIMM: begin
            if ((f3_s == 3'b001 && f7_s != 7'b0000000) ||
                (f3_s == 3'b101 && f7_s != 7'b0000000 && f7_s != 7'b0100000)) begin
               dec_s.illegal = 1'b1;
            end else begin
               dec_s.alu_sel = alu_of(f3_s, (f3_s == 3'b101) & instr_s[30]);
               dec_s.src_imm = 1'b1;
               dec_s.imm     = (f3_s == 3'b001 || f3_s == 3'b101) ?
                               sext({27'd0, instr_s[24:20]}) : sext(imm_i_s);
               dec_s.rs1     = rs1_f_s;
               dec_s.rd      = rd_f_s;
               dec_s.rf_we   = 1'b1;
               dec_s.funct3  = f3_s;
            end
         end
         OPC_OP: begin
            if (f7_s == 7'b0000000 ||
                (f7_s == 7'b0100000 && (f3_s == 3'b000 || f3_s == 3'b101))) begin
               dec_s.alu_sel = alu_of(f3_s, instr_s[30]);
               dec_s.rs1     = rs1_f_s;
               dec_s.rs2     = rs2_f_s;
               dec_s.rd      = rd_f_s;
               dec_s.rf_we   = 1'b1;
               dec_s.funct3  = f3_s;
            end else begin
               dec_s.illegal = 1'b1;
            end
         end
         OPC_FENCE: begin
            if (f3_s == 3'b000) begin
               dec_s.illegal = 1'b0;
            end else begin
               dec_s.illegal = 1'b1;
            end
         end
         OPC_SYSTEM: begin
            if (instr_s == 32'h0000_0073 || instr_s == 32'h0010_0073) begin
               dec_s.illegal = 1'b0;
            end else begin
               dec_s.illegal = 1'b1;
            end
         end
         default: dec_s.illegal = 1'b1;
      endcase
      dec_s.rf_we = dec_s.rf_we & (dec_s.rd != {REG_ADDR_W{1'b0}});
   end

   // Unused source fields decode to 0, so a nonzero load rd can only match a used source.
   assign hazard_s   = ex_load_valid & (ex_load_rd != {REG_ADDR_W{1'b0}}) &
                       ((ex_load_rd == dec_s.rs1) | (ex_load_rd == dec_s.rs2));
   assign in_ready_s = (~out_valid_r | bus.out_ready) & ~hazard_s & ~flush;
   assign accept_s   = bus.in_valid & in_ready_s;

   // Single output register: flush > accept > drain; fields hold whenever nothing is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_r       <= {$bits(bundle_t){1'b0}};
      end else if (flush) begin
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_r       <= dec_s;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign bus.in_ready        = in_ready_s;
   assign bus.out_valid       = out_valid_r;
   assign bus.out_pc          = out_r.pc;
   assign bus.out_alu_sel     = out_r.alu_sel;
   assign bus.out_alu_src_imm = out_r.src_imm;
   assign bus.out_imm         = out_r.imm;
   assign bus.out_rs1         = out_r.rs1;
   assign bus.out_rs2         = out_r.rs2;
   assign bus.out_rd          = out_r.rd;
   assign bus.out_rf_we       = out_r.rf_we;
   assign bus.out_is_load     = out_r.is_load;
   assign bus.out_is_store    = out_r.is_store;
   assign bus.out_is_branch   = out_r.is_branch;
   assign bus.out_is_jal      = out_r.is_jal;
   assign bus.out_is_jalr     = out_r.is_jalr;
   assign bus.out_funct3      = out_r.funct3;
   assign bus.out_illegal     = out_r.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table through a scoreboard queue,
// plus hand sequences for load-use stall, backpressure and flush.
module tb_decode_stage;
   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu_sel;
      logic        src_imm;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rf_we;
      logic [4:0]  cls;      // {load, store, branch, jal, jalr}
      logic [2:0]  funct3;
      logic        illegal;
   } bundle_t;

   typedef struct {
      logic [31:0] instr;
      bundle_t     exp;
   } vec_t;

   localparam int NVEC = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        ex_load_valid;
   logic [4:0]  ex_load_rd;
   int          checks = 0;
   int          errors = 0;
   bundle_t     exp_q[$];
   logic [31:0] instr_q[$];
   vec_t        vecs[NVEC];
   bundle_t     e;
   bundle_t     last_e;

   decode_stage_if #(.XLEN(32), .REG_ADDR_W(5), .ALU_SEL_W(4)) bus ();

   decode_stage #(.XLEN(32), .REG_ADDR_W(5), .ALU_SEL_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .flush         (flush),
      .ex_load_valid (ex_load_valid),
      .ex_load_rd    (ex_load_rd)
   );

   always #5 clk = ~clk;

   function automatic bundle_t mk(input logic [31:0] pc, input logic [3:0] alu, input logic src,
                                  input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic we, input logic [4:0] cls,
                                  input logic [2:0] f3, input logic ill);
      bundle_t b;
      b = '{pc: pc, alu_sel: alu, src_imm: src, imm: imm, rs1: rs1, rs2: rs2, rd: rd,
            rf_we: we, cls: cls, funct3: f3, illegal: ill};
      return b;
   endfunction

   function automatic bundle_t actual();
      return {bus.out_pc, bus.out_alu_sel, bus.out_alu_src_imm, bus.out_imm, bus.out_rs1,
              bus.out_rs2, bus.out_rd, bus.out_rf_we, bus.out_is_load, bus.out_is_store,
              bus.out_is_branch, bus.out_is_jal, bus.out_is_jalr, bus.out_funct3, bus.out_illegal};
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Called at posedge+2; presents one instruction for one cycle.
   task automatic send(input logic [31:0] instr, input bundle_t exp, input bit push);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = exp.pc;
      @(negedge clk);
      check($sformatf("in_ready_%08h", instr), bus.in_ready, 1'b1);
      if (push) begin
         exp_q.push_back(exp);
         instr_q.push_back(instr);
      end
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
   endtask

   // Scoreboard: every bundle taken by execute must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bundle got %h expected none", actual());
         end else begin
            check($sformatf("bundle_%08h", instr_q.pop_front()), actual(), exp_q.pop_front());
         end
      end
   end

   initial begin
      vecs[0]  = '{32'h00500093, mk(32'h0, 4'd0,  1'b1, 32'd5,        5'd0, 5'd0, 5'd1, 1'b1, 5'b00000, 3'd0, 1'b0)};
      vecs[1]  = '{32'h402081B3, mk(32'h0, 4'd1,  1'b0, 32'd0,        5'd1, 5'd2, 5'd3, 1'b1, 5'b00000, 3'd0, 1'b0)};
      vecs[2]  = '{32'h4020D193, mk(32'h0, 4'd9,  1'b1, 32'd2,        5'd1, 5'd0, 5'd3, 1'b1, 5'b00000, 3'd5, 1'b0)};
      vecs[3]  = '{32'h00208463, mk(32'h0, 4'd0,  1'b0, 32'd8,        5'd1, 5'd2, 5'd0, 1'b0, 5'b00100, 3'd0, 1'b0)};
      vecs[4]  = '{32'hFE208EE3, mk(32'h0, 4'd0,  1'b0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 1'b0, 5'b00100, 3'd0, 1'b0)};
      vecs[5]  = '{32'h00000000, mk(32'h0, 4'd0,  1'b0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'd0, 1'b1)};
      vecs[6]  = '{32'h00000033, mk(32'h0, 4'd0,  1'b0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'd0, 1'b0)};
      vecs[7]  = '{32'h123452B7, mk(32'h0, 4'd10, 1'b1, 32'h12345000, 5'd0, 5'd0, 5'd5, 1'b1, 5'b00000, 3'd0, 1'b0)};
      vecs[8]  = '{32'hFFFFF397, mk(32'h0, 4'd11, 1'b1, 32'hFFFFF000, 5'd0, 5'd0, 5'd7, 1'b1, 5'b00000, 3'd0, 1'b0)};
      vecs[9]  = '{32'h010000EF, mk(32'h0, 4'd0,  1'b0, 32'd16,       5'd0, 5'd0, 5'd1, 1'b1, 5'b00010, 3'd0, 1'b0)};
      vecs[10] = '{32'h00008067, mk(32'h0, 4'd0,  1'b1, 32'd0,        5'd1, 5'd0, 5'd0, 1'b0, 5'b00001, 3'd0, 1'b0)};
      vecs[11] = '{32'hFFC12303, mk(32'h0, 4'd0,  1'b1, 32'hFFFFFFFC, 5'd2, 5'd0, 5'd6, 1'b1, 5'b10000, 3'd2, 1'b0)};
      vecs[12] = '{32'h0071A423, mk(32'h0, 4'd0,  1'b1, 32'd8,        5'd3, 5'd7, 5'd0, 1'b0, 5'b01000, 3'd2, 1'b0)};
      vecs[13] = '{32'h00003003, mk(32'h0, 4'd0,  1'b0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'd0, 1'b1)};
      vecs[14] = '{32'h40006033, mk(32'h0, 4'd0,  1'b0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'd0, 1'b1)};
      vecs[15] = '{32'h40001013, mk(32'h0, 4'd0,  1'b0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'd0, 1'b1)};
      vecs[16] = '{32'h00000073, mk(32'h0, 4'd0,  1'b0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'd0, 1'b0)};
      vecs[17] = '{32'h0062B233, mk(32'h0, 4'd3,  1'b0, 32'd0,        5'd5, 5'd6, 5'd4, 1'b1, 5'b00000, 3'd3, 1'b0)};
      vecs[18] = '{32'h00002063, mk(32'h0, 4'd0,  1'b0, 32'd0,        5'd0, 5'd0, 5'd0, 1'b0, 5'b00000, 3'd0, 1'b1)};
      vecs[19] = '{32'hFFF0C113, mk(32'h0, 4'd6,  1'b1, 32'hFFFFFFFF, 5'd1, 5'd0, 5'd2, 1'b1, 5'b00000, 3'd4, 1'b0)};

      reset         = 1'b1;
      flush         = 1'b0;
      ex_load_valid = 1'b0;
      ex_load_rd    = 5'd0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'd0;
      bus.in_pc     = 32'd0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;

      @(negedge clk);
      check("reset_out_valid", bus.out_valid, 1'b0);
      check("reset_bundle", actual(), {$bits(bundle_t){1'b0}});
      check("reset_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      #2;

      // Back-to-back vectors; PC advances by 4 per instruction starting at 0x100.
      for (int i = 0; i < NVEC; i++) begin
         e    = vecs[i].exp;
         e.pc = 32'h100 + 32'(4 * i);
         send(vecs[i].instr, e, 1'b1);
         last_e = e;
      end
      idle(2);
      @(negedge clk);
      check("drain_out_valid", bus.out_valid, 1'b0);
      check("drain_fields_hold", actual(), last_e);
      @(posedge clk);
      #2;

      // Load-use hazard on rs1/rs2 of ADD x6,x5,x5: bubble, then accept once the load leaves.
      ex_load_valid = 1'b1;
      ex_load_rd    = 5'd5;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h00528333;
      bus.in_pc     = 32'h200;
      @(negedge clk);
      check("hazard_in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      #2;
      @(negedge clk);
      check("hazard_bubble", bus.out_valid, 1'b0);
      @(posedge clk);
      #2;
      ex_load_valid = 1'b0;
      send(32'h00528333, mk(32'h200, 4'd0, 1'b0, 32'd0, 5'd5, 5'd5, 5'd6, 1'b1, 5'b00000, 3'd0, 1'b0), 1'b1);
      idle(2);

      // rs2-only hazard (store), unused rs1 field of LUI, and load into x0.
      ex_load_valid = 1'b1;
      ex_load_rd    = 5'd7;
      bus.in_instr  = 32'h0071A423;
      @(negedge clk);
      check("hazard_rs2_store", bus.in_ready, 1'b0);
      @(posedge clk);
      #2;
      ex_load_rd   = 5'd8;
      bus.in_instr = 32'h123452B7;
      @(negedge clk);
      check("no_hazard_lui_field", bus.in_ready, 1'b1);
      @(posedge clk);
      #2;
      ex_load_rd   = 5'd0;
      bus.in_instr = 32'h00000033;
      @(negedge clk);
      check("no_hazard_x0", bus.in_ready, 1'b1);
      @(posedge clk);
      #2;
      ex_load_valid = 1'b0;

      // Backpressure for 3 cycles with a competing input, then flush during the stall.
      bus.out_ready = 1'b0;
      e = mk(32'h300, 4'd0, 1'b1, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1, 5'b00000, 3'd0, 1'b0);
      send(32'h00500093, e, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h402081B3;
      bus.in_pc    = 32'h304;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("stall_out_valid_%0d", k), bus.out_valid, 1'b1);
         check($sformatf("stall_in_ready_%0d", k), bus.in_ready, 1'b0);
         check($sformatf("stall_bundle_%0d", k), actual(), e);
         @(posedge clk);
         #2;
      end
      flush = 1'b1;
      @(negedge clk);
      check("flush_stall_in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      #2;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_stall_out_valid", bus.out_valid, 1'b0);
      check("flush_fields_hold", actual(), e);
      @(posedge clk);
      #2;

      // Flush beats an otherwise acceptable instruction on a free output.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h00500093;
      bus.in_pc     = 32'h308;
      flush         = 1'b1;
      @(negedge clk);
      check("flush_free_in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      #2;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_free_out_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      #2;

      idle(2);
      @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
